// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM: decodes opcode per state into datapath enables/selects.
// Outputs are combinational from state+opcode; 2..5 cycles per instruction, no backpressure.
module control_fsm (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic       i_zero,
  output logic [3:0] o_state,
  output logic       o_PCWre,
  output logic       o_IRWre,
  output logic       o_RegWre,
  output logic       o_mRD,
  output logic       o_mWR,
  output logic       o_WrRegData,
  output logic       o_DBDataSrc,
  output logic [1:0] o_RegOut,
  output logic       o_ALUSrcB,
  output logic       o_ExtSel,
  output logic [2:0] o_ALUOp,
  output logic [1:0] o_PCSrc
);

  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_EXA = 4'd2, S_WBA = 4'd3, S_EXB = 4'd4,
    S_EXM = 4'd5, S_MEM = 4'd6, S_WBL = 4'd7, S_HALT = 4'd8
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000, OP_AND = 6'b010001, OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLT  = 6'b100110, OP_SW  = 6'b110000, OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100, OP_J   = 6'b111000, OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010, OP_HALT = 6'b111111;

  state_t     r_state;
  state_t     w_next;
  logic       w_is_alu;
  logic       w_is_imm;
  logic [2:0] w_alu_fn;
  logic       w_pcwre, w_irwre, w_regwre, w_mrd, w_mwr;

  // ALU-class decode shared by EXA and WBA so operands stay stable into writeback
  always_comb begin
    w_is_alu = 1'b1;
    w_alu_fn = 3'b000;
    case (i_opcode)
      OP_ADD, OP_ADDI: w_alu_fn = 3'b000;
      OP_SUB:          w_alu_fn = 3'b001;
      OP_OR, OP_ORI:   w_alu_fn = 3'b010;
      OP_AND:          w_alu_fn = 3'b011;
      OP_SLT:          w_alu_fn = 3'b100;
      default:         w_is_alu = 1'b0;
    endcase
  end

  assign w_is_imm = (i_opcode == OP_ADDI) || (i_opcode == OP_ORI);

  always_comb begin
    w_next      = r_state;
    w_pcwre     = 1'b0;
    w_irwre     = 1'b0;
    w_regwre    = 1'b0;
    w_mrd       = 1'b0;
    w_mwr       = 1'b0;
    o_WrRegData = 1'b0;
    o_DBDataSrc = 1'b0;
    o_RegOut    = 2'b00;
    o_ALUSrcB   = 1'b0;
    o_ExtSel    = 1'b0;
    o_ALUOp     = 3'b000;
    o_PCSrc     = 2'b00;
    case (r_state)
      S_IF: begin
        w_irwre = 1'b1;
        w_next  = S_ID;
      end
      S_ID: begin
        if (w_is_alu) begin
          w_next = S_EXA;
        end else if (i_opcode == OP_BEQ) begin
          w_next = S_EXB;
        end else if (i_opcode == OP_LW || i_opcode == OP_SW) begin
          w_next = S_EXM;
        end else if (i_opcode == OP_HALT) begin
          w_next = S_HALT;
        end else begin
          // j/jr/jal retire here; illegal opcodes fall through as a nop
          w_next  = S_IF;
          w_pcwre = 1'b1;
          case (i_opcode)
            OP_J:    o_PCSrc = 2'b11;
            OP_JR:   o_PCSrc = 2'b10;
            OP_JAL: begin
              o_PCSrc     = 2'b11;
              w_regwre    = 1'b1;
              o_RegOut    = 2'b00;
              o_WrRegData = 1'b0;
            end
            default: o_PCSrc = 2'b00;
          endcase
        end
      end
      S_EXA, S_WBA: begin
        o_ALUOp   = w_alu_fn;
        o_ALUSrcB = w_is_imm;
        o_ExtSel  = (i_opcode != OP_ORI);
        if (r_state == S_EXA) begin
          w_next = S_WBA;
        end else begin
          w_next      = S_IF;
          w_regwre    = 1'b1;
          o_WrRegData = 1'b1;
          o_RegOut    = w_is_imm ? 2'b01 : 2'b10;
          w_pcwre     = 1'b1;
        end
      end
      S_EXB: begin
        o_ALUOp = 3'b001;
        w_pcwre = 1'b1;
        o_PCSrc = i_zero ? 2'b01 : 2'b00;
        w_next  = S_IF;
      end
      S_EXM: begin
        o_ALUOp   = 3'b000;
        o_ALUSrcB = 1'b1;
        o_ExtSel  = 1'b1;
        w_next    = S_MEM;
      end
      S_MEM: begin
        if (i_opcode == OP_LW) begin
          w_mrd  = 1'b1;
          w_next = S_WBL;
        end else begin
          w_mwr   = (i_opcode == OP_SW);
          w_pcwre = (i_opcode == OP_SW);
          w_next  = S_IF;
        end
      end
      S_WBL: begin
        w_regwre    = 1'b1;
        o_RegOut    = 2'b01;
        o_WrRegData = 1'b1;
        o_DBDataSrc = 1'b1;
        w_mrd       = 1'b1;
        w_pcwre     = 1'b1;
        w_next      = S_IF;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IF;
    else         r_state <= w_next;
  end

  // Reset kills every write enable immediately, abandoning any in-flight instruction
  assign o_PCWre  = w_pcwre  & ~i_reset;
  assign o_IRWre  = w_irwre  & ~i_reset;
  assign o_RegWre = w_regwre & ~i_reset;
  assign o_mRD    = w_mrd    & ~i_reset;
  assign o_mWR    = w_mwr    & ~i_reset;
  assign o_state  = r_state;

endmodule

// File: tb/tb_control_fsm.sv
// Randomized instruction stream checked against a per-instruction-class timeline model.
module tb_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       zero;
  logic [3:0] state;
  logic       PCWre, IRWre, RegWre, mRD, mWR, WrRegData, DBDataSrc, ALUSrcB, ExtSel;
  logic [1:0] RegOut, PCSrc;
  logic [2:0] ALUOp;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int C_ALU = 0, C_BEQ = 1, C_SW = 2, C_LW = 3, C_JMP = 4, C_HALT = 5;

  control_fsm dut (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_zero(zero),
    .o_state(state), .o_PCWre(PCWre), .o_IRWre(IRWre), .o_RegWre(RegWre),
    .o_mRD(mRD), .o_mWR(mWR), .o_WrRegData(WrRegData), .o_DBDataSrc(DBDataSrc),
    .o_RegOut(RegOut), .o_ALUSrcB(ALUSrcB), .o_ExtSel(ExtSel), .o_ALUOp(ALUOp),
    .o_PCSrc(PCSrc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t op=%b)", tag, obs, exp, $time, opcode);
    end
  endtask

  function automatic int classify(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000,
      6'b010001, 6'b010010, 6'b100110: return C_ALU;
      6'b110100: return C_BEQ;
      6'b110000: return C_SW;
      6'b110001: return C_LW;
      6'b111111: return C_HALT;
      default:   return C_JMP;
    endcase
  endfunction

  // Cycles per instruction from the latency table; halt is observed for 2 + 10 cycles
  function automatic int instr_len(input int cls);
    case (cls)
      C_ALU:   return 4;
      C_BEQ:   return 3;
      C_SW:    return 4;
      C_LW:    return 5;
      C_JMP:   return 2;
      default: return 12;
    endcase
  endfunction

  function automatic logic [3:0] path_state(input int cls, input int k);
    logic [3:0] p [5];
    if (k < 2) return 4'(k);
    case (cls)
      C_ALU:   p = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      C_BEQ:   p = '{4'd0, 4'd1, 4'd4, 4'd0, 4'd0};
      C_SW:    p = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd0};
      C_LW:    p = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7};
      default: p = '{4'd0, 4'd1, 4'd8, 4'd8, 4'd8};
    endcase
    return (k < 5) ? p[k] : 4'd8;
  endfunction

  function automatic logic [2:0] alu_fn(input logic [5:0] op);
    case (op)
      6'b000001: return 3'd1;
      6'b010000, 6'b010010: return 3'd2;
      6'b010001: return 3'd3;
      6'b100110: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

  // Runs one instruction from an IF-cycle negedge; abort_k >= 0 asserts reset in that cycle
  task automatic run_instr(input logic [5:0] op, input int abort_k);
    int  cls = classify(op);
    int  len = instr_len(cls);
    bit  last, imm;
    logic [1:0] pcsrc_exp;
    imm = (op == 6'b000010) || (op == 6'b010010);
    for (int k = 0; k < len; k++) begin
      if (k == 0) opcode = op;
      zero = 1'($urandom);
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        check("abort_mWR", 32'(mWR), 0);
        check("abort_en", {PCWre, IRWre, RegWre, mRD, mWR}, 0);
        @(negedge clk);
        #1;
        check("abort_state", 32'(state), 0);
        reset = 1'b0;
        return;
      end
      #1;
      last = (k == len - 1) && (cls != C_HALT);
      check("state", 32'(state), 32'(path_state(cls, k)));
      check("IRWre", 32'(IRWre), 32'(k == 0));
      check("PCWre", 32'(PCWre), 32'(last));
      check("RegWre", 32'(RegWre), 32'(last && (cls == C_ALU || cls == C_LW || op == 6'b111010)));
      check("mRD", 32'(mRD), 32'(cls == C_LW && k >= 3));
      check("mWR", 32'(mWR), 32'(cls == C_SW && k == 3));
      if (k == 0)
        check("if_selects", {WrRegData, DBDataSrc, RegOut, ALUSrcB, ExtSel, ALUOp, PCSrc}, 0);
      if (last) begin
        case (op)
          6'b111000, 6'b111010: pcsrc_exp = 2'b11;
          6'b111001:            pcsrc_exp = 2'b10;
          6'b110100:            pcsrc_exp = zero ? 2'b01 : 2'b00;
          default:              pcsrc_exp = 2'b00;
        endcase
        check("PCSrc", 32'(PCSrc), 32'(pcsrc_exp));
      end
      if (RegWre) begin
        check("RegOut", 32'(RegOut),
              (op == 6'b111010) ? 0 : (cls == C_LW || imm) ? 1 : 2);
        check("WrRegData", 32'(WrRegData), 32'(op != 6'b111010));
        check("DBDataSrc", 32'(DBDataSrc), 32'(cls == C_LW));
      end
      if (cls == C_ALU && (k == 2 || k == 3)) begin
        check("ALUSrcB", 32'(ALUSrcB), 32'(imm));
        check("ExtSel", 32'(ExtSel), 32'(op != 6'b010010));
        if (k == 2) check("ALUOp", 32'(ALUOp), 32'(alu_fn(op)));
      end
      if (cls == C_BEQ && k == 2) begin
        check("beq_ALUOp", 32'(ALUOp), 1);
        check("beq_ALUSrcB", 32'(ALUSrcB), 0);
      end
      if ((cls == C_SW || cls == C_LW) && k == 2)
        check("exm_ctl", {ALUOp, ALUSrcB, ExtSel}, {3'b000, 1'b1, 1'b1});
      check("mrd_mwr_excl", 32'(mRD & mWR), 0);
      check("pc_reg_excl", 32'(PCWre & RegWre),
            32'(last && (cls == C_ALU || cls == C_LW || op == 6'b111010)));
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_en", {PCWre, IRWre, RegWre, mRD, mWR}, 0);
    @(negedge clk);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_en2", {PCWre, IRWre, RegWre, mRD, mWR}, 0);
    reset = 1'b0;
  endtask

  logic [5:0] legal [13];
  logic [5:0] op;

  initial begin
    legal = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
              6'b100110, 6'b110000, 6'b110001, 6'b110100, 6'b111000, 6'b111001,
              6'b111010};
    reset  = 1'b1;
    opcode = 6'b000000;
    zero   = 1'b0;
    @(negedge clk);
    apply_reset();

    run_instr(6'b000000, -1);
    run_instr(6'b110001, -1);
    run_instr(6'b110100, -1);
    run_instr(6'b110100, -1);
    run_instr(6'b111010, -1);
    run_instr(6'b101010, -1);
    run_instr(6'b110000, 3);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) begin
        op = 6'($urandom);
        if (op == 6'b111111) op = 6'b101011;
      end else begin
        op = legal[$urandom_range(12)];
      end
      run_instr(op, (i % 37 == 5) ? $urandom_range(instr_len(classify(op)) - 1) : -1);
    end

    run_instr(6'b111111, -1);
    apply_reset();
    run_instr(6'b111111, 6);
    run_instr(6'b000010, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
